// File: rtl/stop_watch_pkg.sv
// Shared types and constants for the stop_watch timing block: FSM states,
// time-field maxima and active-low seven-segment digit patterns.
package stop_watch_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic [6:0] MSEC_MAX = 7'd99;
   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

   // Segment order {dp,g,f,e,d,c,b,a}, active-low; entry i is digit i.
   localparam logic [9:0][7:0] SEG_DIGITS = {
      8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
      8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg_decode(input logic [3:0] digit);
      return (digit <= 4'd9) ? SEG_DIGITS[digit] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/stop_watch_if.sv
// Board-pin bundle of the stopwatch: switches and buttons in, FND and LEDs out.
interface stop_watch_if;
   logic [1:0] sw;
   logic       Btn_L;
   logic       Btn_R;
   logic       Btn_U;
   logic       Btn_D;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;
   logic [2:0] led;

   modport master (
      output sw, Btn_L, Btn_R, Btn_U, Btn_D,
      input  fnd_com, fnd_data, led
   );

   modport slave (
      input  sw, Btn_L, Btn_R, Btn_U, Btn_D,
      output fnd_com, fnd_data, led
   );
endinterface

// File: rtl/fnd_controller.sv
// Four-digit multiplexed FND driver: scan counter, field mux, BCD split and
// segment decode, with the digit-2 decimal point blinking at 1 Hz.
module fnd_controller
   import stop_watch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned SCAN_HZ = 1_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);
   localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   logic [SCAN_W-1:0] scan_cnt_q;
   logic [1:0]        digit_idx_q;
   logic [6:0]        lo_field;
   logic [6:0]        hi_field;
   logic [3:0]        digit;

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_cnt_q  <= '0;
         digit_idx_q <= '0;
      end else if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_q  <= '0;
         digit_idx_q <= digit_idx_q + 2'd1;
      end else begin
         scan_cnt_q  <= scan_cnt_q + SCAN_W'(1);
      end
   end

   // NOTE: every output is assigned before any branch, so no latch is inferred.
   always_comb begin
      lo_field = mode ? {1'b0, min}   : msec;
      hi_field = mode ? {2'b00, hour} : {1'b0, sec};
      unique case (digit_idx_q)
         2'd0:    digit = 4'(lo_field % 7'd10);
         2'd1:    digit = 4'(lo_field / 7'd10);
         2'd2:    digit = 4'(hi_field % 7'd10);
         default: digit = 4'(hi_field / 7'd10);
      endcase
      fnd_com  = ~(4'b0001 << digit_idx_q);
      fnd_data = seg_decode(digit);
      if (digit_idx_q == 2'd2 && msec < 7'd50) fnd_data[7] = 1'b0;
   end

endmodule

// File: rtl/stop_watch.sv
// Stopwatch top: button edge detection, STOP/RUN/CLEAR FSM, centisecond divider
// and hh:mm:ss.cc counters. Define BTN_DEBOUNCE_EN for synchronised, debounced buttons.
module stop_watch
   import stop_watch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 100,
   parameter int unsigned SCAN_HZ = 1_000
) (
   input  logic         clk,
   input  logic         reset,
   stop_watch_if.slave  pins
);
   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [1:0]       btn_lvl;      // [0]=Btn_L, [1]=Btn_R
   logic [1:0]       btn_prev_q;
   logic [1:0]       btn_edge;
   logic [DIV_W-1:0] div_q;
   logic             tick;
   logic [6:0]       msec_q;
   logic [5:0]       sec_q;
   logic [5:0]       min_q;
   logic [4:0]       hour_q;
   logic             unused_pins;

   assign unused_pins = &{1'b0, pins.sw[1], pins.Btn_U, pins.Btn_D};

`ifdef BTN_DEBOUNCE_EN
   localparam int unsigned SAMPLE_DIV = CLK_HZ / 1_000;
   localparam int unsigned SAMPLE_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);

   logic [1:0]          sync1_q, sync2_q, db_lvl_q;
   logic [SAMPLE_W-1:0] sample_cnt_q;
   logic [7:0]          hist_l_q, hist_r_q;

   // A button counts as pressed only after 8 consecutive high 1 ms samples.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         db_lvl_q     <= '0;
         sample_cnt_q <= '0;
         hist_l_q     <= '0;
         hist_r_q     <= '0;
      end else begin
         sync1_q <= {pins.Btn_R, pins.Btn_L};
         sync2_q <= sync1_q;
         if (sample_cnt_q == SAMPLE_LAST) begin
            sample_cnt_q <= '0;
            hist_l_q     <= {hist_l_q[6:0], sync2_q[0]};
            hist_r_q     <= {hist_r_q[6:0], sync2_q[1]};
         end else begin
            sample_cnt_q <= sample_cnt_q + SAMPLE_W'(1);
         end
         db_lvl_q <= {&hist_r_q, &hist_l_q};
      end
   end

   assign btn_lvl = db_lvl_q;
`else
   assign btn_lvl = {pins.Btn_R, pins.Btn_L};
`endif

   always_ff @(posedge clk) begin
      if (!reset) btn_prev_q <= '0;
      else        btn_prev_q <= btn_lvl;
   end

   assign btn_edge = btn_lvl & ~btn_prev_q;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= STOP;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pins.led = 3'b001;
      unique case (state_q)
         STOP: begin
            if (btn_edge[1])      state_d = RUN;
            else if (btn_edge[0]) state_d = CLEAR;
         end
         RUN: begin
            pins.led = 3'b010;
            if (btn_edge[1]) state_d = STOP;
         end
         CLEAR: begin
            pins.led = 3'b100;
            state_d  = STOP;
         end
         default: state_d = STOP;
      endcase
   end

   assign tick = (state_q == RUN) && (div_q == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!reset || state_q == CLEAR) begin
         div_q  <= '0;
         msec_q <= '0;
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
      end else begin
         if (state_q == RUN) div_q <= tick ? '0 : div_q + DIV_W'(1);
         // Ripple carry through the fields; 23:59:59.99 rolls to all zeros.
         if (tick) begin
            if (msec_q != MSEC_MAX) begin
               msec_q <= msec_q + 7'd1;
            end else begin
               msec_q <= '0;
               if (sec_q != SEC_MAX) begin
                  sec_q <= sec_q + 6'd1;
               end else begin
                  sec_q <= '0;
                  if (min_q != MIN_MAX) begin
                     min_q <= min_q + 6'd1;
                  end else begin
                     min_q  <= '0;
                     hour_q <= (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                  end
               end
            end
         end
      end
   end

   fnd_controller #(
      .CLK_HZ  (CLK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) u_fnd (
      .clk      (clk),
      .reset    (reset),
      .mode     (pins.sw[0]),
      .msec     (msec_q),
      .sec      (sec_q),
      .min      (min_q),
      .hour     (hour_q),
      .fnd_com  (pins.fnd_com),
      .fnd_data (pins.fnd_data)
   );

endmodule

// File: tb/tb_stop_watch.sv
// Self-checking bench for stop_watch at a scaled clock: outputs are compared every
// cycle against a model that tracks elapsed centiseconds as a single integer.
module tb_stop_watch;
   localparam int unsigned CLK_HZ  = 10_000;
   localparam int unsigned TICK_HZ = 100;
   localparam int unsigned SCAN_HZ = 1_000;
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;   // cycles per centisecond
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;   // cycles per scanned digit
   localparam int DAY_CS   = 24 * 60 * 60 * 100;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   stop_watch_if pins ();

   stop_watch #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pins  (pins)
   );

   always #5 clk = ~clk;

   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef enum {M_STOP, M_RUN, M_CLEAR} mstate_t;
   mstate_t m_state     = M_STOP;
   int      run_cycles  = 0;   // clock edges spent in RUN since last clear
   int      scan_cycles = 0;   // clock edges since reset released
   int      offset_cs   = 0;   // centiseconds added by the preload
   logic    prev_l = 1'b0, prev_r = 1'b0;
   logic    rise_l, rise_r;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model, advanced on each rising edge.
   always @(posedge clk) begin
      if (!reset) begin
         m_state     = M_STOP;
         run_cycles  = 0;
         scan_cycles = 0;
         offset_cs   = 0;
         prev_l      = 1'b0;
         prev_r      = 1'b0;
      end else begin
         rise_l = pins.Btn_L && !prev_l;
         rise_r = pins.Btn_R && !prev_r;
         scan_cycles++;
         if (m_state == M_RUN) run_cycles++;
         if (m_state == M_CLEAR) begin
            run_cycles = 0;
            offset_cs  = 0;
         end
         case (m_state)
            M_STOP:  if (rise_r) m_state = M_RUN; else if (rise_l) m_state = M_CLEAR;
            M_RUN:   if (rise_r) m_state = M_STOP;
            default: m_state = M_STOP;
         endcase
         prev_l = pins.Btn_L;
         prev_r = pins.Btn_R;
      end
   end

   function automatic int now_cs();
      return ((offset_cs + run_cycles / TICK_DIV) % DAY_CS + DAY_CS) % DAY_CS;
   endfunction

   task automatic expect_outputs(output logic [2:0] e_led, output logic [3:0] e_com,
                                 output logic [7:0] e_data);
      int cs, ms, lo, hi, idx, d;
      cs  = now_cs();
      ms  = cs % 100;
      lo  = pins.sw[0] ? (cs / 6000) % 60 : ms;
      hi  = pins.sw[0] ? cs / 360000      : (cs / 100) % 60;
      idx = (scan_cycles / SCAN_DIV) % 4;
      case (idx)
         0:       d = lo % 10;
         1:       d = lo / 10;
         2:       d = hi % 10;
         default: d = hi / 10;
      endcase
      e_com      = 4'b1111;
      e_com[idx] = 1'b0;
      e_data     = seg_tab[d];
      if (idx == 2 && ms < 50) e_data[7] = 1'b0;
      case (m_state)
         M_RUN:   e_led = 3'b010;
         M_CLEAR: e_led = 3'b100;
         default: e_led = 3'b001;
      endcase
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [2:0] el;
      logic [3:0] ec;
      logic [7:0] ed;
      expect_outputs(el, ec, ed);
      check({tag, " led"},      8'(pins.led),     8'(el));
      check({tag, " fnd_com"},  8'(pins.fnd_com), 8'(ec));
      check({tag, " fnd_data"}, pins.fnd_data,    ed);
   endtask

   task automatic step(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         check_outputs(tag);
      end
   endtask

   task automatic press(input logic l, input logic r, input int len, input string tag);
      pins.Btn_L = l;
      pins.Btn_R = r;
      step(len, tag);
      pins.Btn_L = 1'b0;
      pins.Btn_R = 1'b0;
   endtask

   int kind;

   initial begin
      pins.sw    = 2'b00;
      pins.Btn_L = 1'b0;
      pins.Btn_R = 1'b0;
      pins.Btn_U = 1'b0;
      pins.Btn_D = 1'b0;

      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset led",      8'(pins.led),     8'h01);
      check("reset fnd_com",  8'(pins.fnd_com), 8'h0E);
      check("reset fnd_data", pins.fnd_data,    8'hC0);
      check_outputs("in reset");
      reset = 1'b1;
      step(5, "idle");

      press(1'b0, 1'b1, 1, "run press");
      check("run led", 8'(pins.led), 8'h02);
      step(TICK_DIV, "first tick");
      step(3 * SCAN_DIV, "scan after first tick");

      press(1'b0, 1'b1, 1, "stop press");
      step(TICK_DIV + 7, "stopped hold");

      press(1'b1, 1'b0, 1, "clear press");
      check("clear led", 8'(pins.led), 8'h04);
      step(4 * SCAN_DIV, "after clear");

      press(1'b0, 1'b1, 1, "run again");
      step(250, "running");
      pins.Btn_U = 1'b1;
      pins.Btn_D = 1'b1;
      press(1'b1, 1'b0, 5, "clear while running");
      pins.Btn_U = 1'b0;
      pins.Btn_D = 1'b0;
      step(30, "ignored clear");
      press(0, 1, 3, "stop held");
      step(20, "held stop");
      press(0, 1, 1, "resume");
      step(120, "resumed");

      reset = 1'b0;
      step(1, "reset mid-run");
      check("mid-run reset led",      8'(pins.led),     8'h01);
      check("mid-run reset fnd_com",  8'(pins.fnd_com), 8'h0E);
      check("mid-run reset fnd_data", pins.fnd_data,    8'hC0);
      reset = 1'b1;
      step(5, "after mid-run reset");

      for (int i = 0; i < 24; i++) begin
         kind    = int'($urandom_range(0, 3));
         pins.sw = 2'($urandom_range(0, 3));
         case (kind)
            0:       press(1'b0, 1'b1, int'($urandom_range(1, 4)), "rand run/stop");
            1:       press(1'b1, 1'b0, int'($urandom_range(1, 4)), "rand clear");
            2:       press(1'b1, 1'b1, int'($urandom_range(1, 4)), "rand both");
            default: ;
         endcase
         step(int'($urandom_range(1, 300)), "rand wait");
      end

      if (m_state == M_RUN) press(1'b0, 1'b1, 1, "stop before preload");
      step(2, "before preload");
      force dut.msec_q = 7'd99;
      force dut.sec_q  = 6'd59;
      force dut.min_q  = 6'd59;
      force dut.hour_q = 5'd23;
      #1;
      release dut.msec_q;
      release dut.sec_q;
      release dut.min_q;
      release dut.hour_q;
      offset_cs = DAY_CS - 1 - run_cycles / TICK_DIV;

      pins.sw = 2'b01;
      step(4 * SCAN_DIV, "preload hh.mm");
      pins.sw = 2'b00;
      step(4 * SCAN_DIV, "preload ss.cc");
      press(1'b0, 1'b1, 1, "run to wrap");
      step(TICK_DIV + 10, "wrap");
      press(1'b0, 1'b1, 1, "stop after wrap");
      pins.sw = 2'b01;
      step(4 * SCAN_DIV, "after wrap hh.mm");
      pins.sw = 2'b00;
      step(4 * SCAN_DIV, "after wrap ss.cc");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/stop_watch.md
# stop_watch

Free-running 100 MHz stopwatch with run/stop/clear control, a 4-digit multiplexed seven-segment (FND) display and three status LEDs. It is the top-level timing block of the board design: buttons and switches come in from board pins, and the FND and LED drives go straight out to pins. It counts hundredths of seconds, seconds, minutes and hours. `sw[0]` selects which pair of fields is displayed.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 100: count rate; one centisecond per tick.
- SCAN_HZ, 1_000: digit scan rate; each digit is driven for 1 ms.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sw  in  2  `sw[0]` selects the display mode; `sw[1]` is reserved and ignored.
- Btn_L  in  1  clear request.
- Btn_R  in  1  run/stop toggle.
- Btn_U  in  1  reserved and ignored.
- Btn_D  in  1  reserved and ignored.
- fnd_com  out  4  digit select, active-low one-hot; bit 0 is the rightmost digit.
- fnd_data  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- led  out  3  one-hot state: [0]=STOP, [1]=RUN, [2]=CLEAR.

## Operation
- Buttons are rising-edge detected.
  - A high level lasting one or more cycles is one event.
  - A press held high does not repeat.
- FSM states are STOP, RUN and CLEAR. Reset enters STOP.
- STOP:
  - Btn_R edge goes to RUN.
  - Btn_L edge goes to CLEAR.
  - If both edges arrive in the same cycle, Btn_R wins.
- RUN:
  - Btn_R edge goes to STOP.
  - Btn_L is ignored.
- CLEAR lasts exactly one cycle and then goes to STOP unconditionally.
- Tick divider:
  - Counts 0..CLK_HZ/TICK_HZ−1, which is 0..999_999 at the defaults.
  - Advances only in RUN and holds its value in STOP.
  - It is zeroed in CLEAR and by reset.
  - It produces a 1-cycle tick at terminal count.
- Time counters are unsigned BCD-friendly binary: msec 0..99, sec 0..59, min 0..59, hour 0..23.
  - A tick increments msec.
  - Each field carries into the next on wrap.
  - 23:59:59.99 wraps to 00:00:00.00.
  - All fields are zeroed in CLEAR and by reset.
- Display mode `sw[0]=0` shows digits 3..0 as sec_tens, sec_ones, msec_tens, msec_ones.
- Display mode `sw[0]=1` shows digits 3..0 as hour_tens, hour_ones, min_tens, min_ones.
- Decimal point:
  - The dp on digit 2 is lit (0) when msec < 50, giving a 1 Hz blink.
  - All other dp bits are 1.
- Digit patterns for 0..9, active-low:
  - C0 F9 A4 B0 99
  - 92 82 F8 80 90

## Timing
- Reset values:
  - State STOP, led=3'b001.
  - All counters 0, scan index 0.
  - fnd_com=4'b1110, fnd_data=8'hC0.
- A button edge sampled at cycle n updates the state, and therefore led, at edge n+1.
- A tick counts the cycle after the divider reaches its terminal value.
  - The first msec increment occurs 1_000_000 cycles after entering RUN.
- Scan timing:
  - The scan counter advances the digit index every CLK_HZ/SCAN_HZ cycles, cycling 0→1→2→3→0.
  - The scan counter runs in every state.
- fnd_com and fnd_data are combinational from registered index, mode and counters.
- A change on `sw` is visible within one cycle; `sw` is not synchronised and is used as static.
- Reset asserted mid-run returns every register to its reset value on the next edge.

## Configuration
- BTN_DEBOUNCE_EN defined:
  - Each button passes a 2-flop synchroniser plus a debouncer.
  - The debouncer samples at 1 kHz and requires 8 consecutive high samples before the edge is detected.
  - Pulses shorter than 8 ms are ignored.
- BTN_DEBOUNCE_EN undefined:
  - Raw inputs go straight into the edge detector.
  - A 1-cycle pulse is accepted. This is the simulation build.

## Structure
- Package `stop_watch_pkg` holds:
  - the state enum (STOP/RUN/CLEAR);
  - the 7-segment digit constants;
  - the field maxima (99/59/59/23).
- Sub-module `fnd_controller` owns the scan counter, the digit mux, the BCD split and the segment decode.
- The top level holds the button edge/debounce logic, the FSM, the tick divider and the time counters.

## Test plan
- Reset held low 2 cycles, then released: led=001, fnd_com=1110, fnd_data=C0, counters 0.
- Btn_R pulse for 1 cycle, then wait 10 ms (1_000_000 cycles): led=010, msec=1, and digit 0 shows F9 when scanned.
- Second Btn_R pulse, then wait 10 ms: led=001 and msec is frozen at its value at the stop.
- Btn_L pulse while stopped: led=100 for one cycle, then 001, with all counters 0.
- Btn_L pulse while running is ignored; Btn_R again resumes from the held value.
- Preload 23:59:59.99 and run to the next tick: all fields become 0.
- With sw=1, digits show hour/min; with sw=0, digits show sec/msec.
- Over 4 ms, fnd_com steps 1110→1101→1011→0111.
